// File: rtl/xif_issue_initiator.sv
// Core-side initiator for the CORE-V-XIF issue and result channels: presents one
// offload candidate at a time, reports the handshake outcome and tracks IDs until results return.
module xif_issue_initiator #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NrIds   = 4,
    parameter int unsigned IdWidth = $clog2(NrIds)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_valid_i,
    input  logic [31:0]          instr_i,
    output logic                 instr_ready_o,
    input  logic [2*XLEN-1:0]    rs_i,
    input  logic [1:0]           rs_valid_i,
    output logic                 issue_valid_o,
    input  logic                 issue_ready_i,
    output logic [31:0]          issue_instr_o,
    output logic [IdWidth-1:0]   issue_id_o,
    output logic [2*XLEN-1:0]    issue_rs_o,
    output logic [1:0]           issue_rs_valid_o,
    input  logic                 issue_accept_i,
    input  logic                 issue_writeback_i,
    input  logic [1:0]           issue_register_read_i,
    output logic                 outcome_valid_o,
    output logic                 outcome_accept_o,
    output logic                 outcome_writeback_o,
    output logic [IdWidth-1:0]   outcome_id_o,
    input  logic                 result_valid_i,
    output logic                 result_ready_o,
    input  logic [IdWidth-1:0]   result_id_i,
    input  logic [XLEN-1:0]      result_data_i,
    input  logic                 result_we_i,
    output logic                 wb_valid_o,
    output logic [IdWidth-1:0]   wb_id_o,
    output logic [XLEN-1:0]      wb_data_o,
    output logic                 id_error_o,
    output logic                 busy_o
);

    typedef enum logic {
        IDLE,
        REQ
    } state_e;

    state_e               state_q, state_d;
    logic [IdWidth-1:0]   next_id_q, next_id_d;
    logic [NrIds-1:0]     busy_q, busy_d;
    logic [NrIds-1:0]     wb_pending_q, wb_pending_d;
    logic [31:0]          instr_q, instr_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [IdWidth-1:0]   wb_id_q, wb_id_d;
    logic [XLEN-1:0]      wb_data_q, wb_data_d;
    logic                 id_error_q, id_error_d;
    logic                 handshake;
    logic                 unused_register_read;

    // The register-read response carries no information the pipeline needs here.
    assign unused_register_read = ^issue_register_read_i;

    always_comb begin
        state_d       = state_q;
        next_id_d     = next_id_q;
        busy_d        = busy_q;
        wb_pending_d  = wb_pending_q;
        instr_d       = instr_q;
        wb_valid_d    = 1'b0;
        wb_id_d       = wb_id_q;
        wb_data_d     = wb_data_q;
        id_error_d    = 1'b0;
        instr_ready_o = 1'b0;
        issue_valid_o = 1'b0;
        handshake     = 1'b0;

        case (state_q)
            IDLE: begin
                instr_ready_o = instr_valid_i && !busy_q[next_id_q];
                if (instr_ready_o) begin
                    instr_d = instr_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                issue_valid_o = 1'b1;
                handshake     = issue_ready_i;
                if (handshake) begin
                    next_id_d = next_id_q + IdWidth'(1);
                    state_d   = IDLE;
                    if (issue_accept_i && issue_writeback_i) begin
                        busy_d[next_id_q]       = 1'b1;
                        wb_pending_d[next_id_q] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A result never targets the ID being issued (it cannot be busy), so both updates compose.
        if (result_valid_i) begin
            if (busy_q[result_id_i]) begin
                busy_d[result_id_i]       = 1'b0;
                wb_pending_d[result_id_i] = 1'b0;
                if (result_we_i && wb_pending_q[result_id_i]) begin
                    wb_valid_d = 1'b1;
                    wb_id_d    = result_id_i;
                    wb_data_d  = result_data_i;
                end
            end else begin
                id_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            next_id_q    <= '0;
            busy_q       <= '0;
            wb_pending_q <= '0;
            instr_q      <= '0;
            wb_valid_q   <= 1'b0;
            wb_id_q      <= '0;
            wb_data_q    <= '0;
            id_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_id_q    <= next_id_d;
            busy_q       <= busy_d;
            wb_pending_q <= wb_pending_d;
            instr_q      <= instr_d;
            wb_valid_q   <= wb_valid_d;
            wb_id_q      <= wb_id_d;
            wb_data_q    <= wb_data_d;
            id_error_q   <= id_error_d;
        end
    end

    assign issue_instr_o       = instr_q;
    assign issue_id_o          = next_id_q;
    assign issue_rs_o          = rs_i;
    assign issue_rs_valid_o    = rs_valid_i;
    assign outcome_valid_o     = handshake;
    assign outcome_accept_o    = handshake && issue_accept_i;
    assign outcome_writeback_o = handshake && issue_writeback_i;
    assign outcome_id_o        = next_id_q;
    assign result_ready_o      = rst_ni;
    assign wb_valid_o          = wb_valid_q;
    assign wb_id_o             = wb_id_q;
    assign wb_data_o           = wb_data_q;
    assign id_error_o          = id_error_q;
    assign busy_o              = (state_q == REQ) || (|busy_q);

endmodule

// File: tb/tb_xif_issue_initiator.sv
// Scoreboard bench for xif_issue_initiator: issue handshakes, ID tracking and result writeback.
module tb_xif_issue_initiator;
    localparam int XLEN = 64;
    localparam int IW   = 2;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            instr_valid_i = 1'b0;
    logic [31:0]     instr_i = '0;
    logic            instr_ready_o;
    logic [2*XLEN-1:0] rs_i = '0;
    logic [1:0]      rs_valid_i = '0;
    logic            issue_valid_o;
    logic            issue_ready_i = 1'b0;
    logic [31:0]     issue_instr_o;
    logic [IW-1:0]   issue_id_o;
    logic [2*XLEN-1:0] issue_rs_o;
    logic [1:0]      issue_rs_valid_o;
    logic            issue_accept_i = 1'b0;
    logic            issue_writeback_i = 1'b0;
    logic [1:0]      issue_register_read_i = '0;
    logic            outcome_valid_o, outcome_accept_o, outcome_writeback_o;
    logic [IW-1:0]   outcome_id_o;
    logic            result_valid_i = 1'b0;
    logic            result_ready_o;
    logic [IW-1:0]   result_id_i = '0;
    logic [XLEN-1:0] result_data_i = '0;
    logic            result_we_i = 1'b0;
    logic            wb_valid_o;
    logic [IW-1:0]   wb_id_o;
    logic [XLEN-1:0] wb_data_o;
    logic            id_error_o;
    logic            busy_o;

    int checks = 0;
    int errors = 0;
    logic [IW+XLEN-1:0] exp_q[$];

    xif_issue_initiator #(.XLEN(XLEN), .NrIds(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .instr_valid_i(instr_valid_i), .instr_i(instr_i), .instr_ready_o(instr_ready_o),
        .rs_i(rs_i), .rs_valid_i(rs_valid_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_instr_o(issue_instr_o), .issue_id_o(issue_id_o),
        .issue_rs_o(issue_rs_o), .issue_rs_valid_o(issue_rs_valid_o),
        .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i),
        .issue_register_read_i(issue_register_read_i),
        .outcome_valid_o(outcome_valid_o), .outcome_accept_o(outcome_accept_o),
        .outcome_writeback_o(outcome_writeback_o), .outcome_id_o(outcome_id_o),
        .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
        .result_id_i(result_id_i), .result_data_i(result_data_i), .result_we_i(result_we_i),
        .wb_valid_o(wb_valid_o), .wb_id_o(wb_id_o), .wb_data_o(wb_data_o),
        .id_error_o(id_error_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Writeback scoreboard: every wb pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_ni && wb_valid_o) begin
            logic [IW+XLEN-1:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got id=%0d data=%h, none expected", wb_id_o, wb_data_o);
            end else begin
                e = exp_q.pop_front();
                if ({wb_id_o, wb_data_o} !== e) begin
                    errors++;
                    $display("FAIL wb_match: got id=%0d data=%h want id=%0d data=%h",
                             wb_id_o, wb_data_o, e[IW+XLEN-1:XLEN], e[XLEN-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_result(input logic [IW-1:0] id, input logic [XLEN-1:0] data,
                                input logic we, input logic expect_wb);
        result_valid_i = 1'b1; result_id_i = id; result_data_i = data; result_we_i = we;
        if (expect_wb) exp_q.push_back({id, data});
        tick();
        result_valid_i = 1'b0; result_we_i = 1'b0;
    endtask

    // Full IDLE->REQ->handshake sequence with ready asserted on the first REQ cycle.
    task automatic issue_one(input logic [31:0] ins, input logic acc, input logic wbk,
                             input logic [IW-1:0] exp_id);
        instr_valid_i = 1'b1; instr_i = ins;
        #1;
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL io_instr_ready: got %b want 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        issue_ready_i = 1'b1; issue_accept_i = acc; issue_writeback_i = wbk;
        #1;
        checks++; if (issue_valid_o !== 1'b1) begin errors++; $display("FAIL io_issue_valid: got %b want 1", issue_valid_o); end
        checks++; if (issue_instr_o !== ins) begin errors++; $display("FAIL io_issue_instr: got %h want %h", issue_instr_o, ins); end
        checks++; if (outcome_id_o !== exp_id || issue_id_o !== exp_id) begin errors++; $display("FAIL io_id: got %0d/%0d want %0d", issue_id_o, outcome_id_o, exp_id); end
        checks++; if ({outcome_valid_o, outcome_accept_o, outcome_writeback_o} !== {1'b1, acc, wbk}) begin errors++; $display("FAIL io_outcome: got %b want %b", {outcome_valid_o, outcome_accept_o, outcome_writeback_o}, {1'b1, acc, wbk}); end
        tick();
        issue_ready_i = 1'b0; issue_accept_i = 1'b0; issue_writeback_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
        #1;
        checks++; if ({issue_valid_o, instr_ready_o, outcome_valid_o, wb_valid_o, id_error_o, busy_o} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {issue_valid_o, instr_ready_o, outcome_valid_o, wb_valid_o, id_error_o, busy_o}); end
        checks++; if (issue_id_o !== 2'd0 || issue_instr_o !== 32'd0) begin errors++; $display("FAIL reset_regs: got id=%0d instr=%h want 0", issue_id_o, issue_instr_o); end
        checks++; if (result_ready_o !== 1'b1) begin errors++; $display("FAIL reset_result_ready: got %b want 1", result_ready_o); end
    endtask

    task automatic test_accept_writeback();
        rs_i = {64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        rs_valid_i = 2'b01;
        issue_one(32'h0200_7057, 1'b1, 1'b1, 2'd0);
        #1;
        checks++; if (issue_rs_o !== rs_i || issue_rs_valid_o !== 2'b01) begin errors++; $display("FAIL aw_operands: got %h/%b want %h/01", issue_rs_o, issue_rs_valid_o, rs_i); end
        checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL aw_valid_one_cycle: got %b want 0", issue_valid_o); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL aw_busy_held: got %b want 1", busy_o); end
            tick();
        end
        drive_result(2'd0, 64'h1234, 1'b1, 1'b1);
        #1;
        checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== 64'h1234) begin errors++; $display("FAIL aw_wb: got %b/%h want 1/1234", wb_valid_o, wb_data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL aw_busy_clear: got %b want 0", busy_o); end
        tick();
    endtask

    task automatic test_backpressure();
        instr_valid_i = 1'b1; instr_i = 32'h1234_5678;
        tick();
        instr_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            issue_ready_i = (c == 3); issue_accept_i = 1'b1;
            #1;
            checks++; if (issue_valid_o !== 1'b1 || issue_instr_o !== 32'h1234_5678 || issue_id_o !== 2'd1) begin errors++; $display("FAIL bp_stable c%0d: got %b/%h/%0d want 1/12345678/1", c, issue_valid_o, issue_instr_o, issue_id_o); end
            checks++; if (outcome_valid_o !== (c == 3)) begin errors++; $display("FAIL bp_outcome c%0d: got %b want %b", c, outcome_valid_o, c == 3); end
            tick();
        end
        issue_ready_i = 1'b0; issue_accept_i = 1'b0;
        #1;
        checks++; if (issue_id_o !== 2'd2 || busy_o !== 1'b0) begin errors++; $display("FAIL bp_after: got id=%0d busy=%b want 2/0", issue_id_o, busy_o); end
    endtask

    task automatic test_reject();
        issue_one(32'h0000_0057, 1'b0, 1'b0, 2'd2);
        #1;
        checks++; if (issue_id_o !== 2'd3 || busy_o !== 1'b0) begin errors++; $display("FAIL rej_after: got id=%0d busy=%b want 3/0", issue_id_o, busy_o); end
        issue_one(32'h0000_1057, 1'b1, 1'b0, 2'd3);
        #1;
        checks++; if (issue_id_o !== 2'd0 || busy_o !== 1'b0) begin errors++; $display("FAIL wrap_after: got id=%0d busy=%b want 0/0", issue_id_o, busy_o); end
    endtask

    task automatic test_id_exhaustion();
        for (int i = 0; i < 4; i++) issue_one(32'h100 + i, 1'b1, 1'b1, IW'(i));
        instr_valid_i = 1'b1; instr_i = 32'hCAFE_0001;
        #1;
        checks++; if (instr_ready_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL ex_blocked: got rdy=%b busy=%b want 0/1", instr_ready_o, busy_o); end
        tick();
        result_valid_i = 1'b1; result_id_i = 2'd0; result_data_i = 64'h55; result_we_i = 1'b1;
        exp_q.push_back({2'd0, 64'h55});
        #1;
        checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL ex_no_bypass: got %b want 0", instr_ready_o); end
        tick();
        result_valid_i = 1'b0; result_we_i = 1'b0;
        #1;
        checks++; if (instr_ready_o !== 1'b1 || issue_id_o !== 2'd0) begin errors++; $display("FAIL ex_reopen: got rdy=%b id=%0d want 1/0", instr_ready_o, issue_id_o); end
        tick();
        // Handshake for ID 0 and result for ID 1 land in the same cycle.
        instr_valid_i = 1'b0;
        issue_ready_i = 1'b1; issue_accept_i = 1'b1; issue_writeback_i = 1'b1;
        result_valid_i = 1'b1; result_id_i = 2'd1; result_data_i = 64'h66; result_we_i = 1'b1;
        exp_q.push_back({2'd1, 64'h66});
        #1;
        checks++; if (outcome_valid_o !== 1'b1 || outcome_id_o !== 2'd0 || issue_instr_o !== 32'hCAFE_0001) begin errors++; $display("FAIL ex_reissue: got %b/%0d/%h want 1/0/cafe0001", outcome_valid_o, outcome_id_o, issue_instr_o); end
        tick();
        issue_ready_i = 1'b0; issue_accept_i = 1'b0; issue_writeback_i = 1'b0;
        result_valid_i = 1'b0; result_we_i = 1'b0;
        drive_result(2'd2, 64'h77, 1'b1, 1'b1);
        drive_result(2'd3, 64'h88, 1'b0, 1'b0);
        drive_result(2'd0, 64'h99, 1'b1, 1'b1);
        #1;
        checks++; if (id_error_o !== 1'b0) begin errors++; $display("FAIL ex_no_error: got %b want 0", id_error_o); end
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ex_drained: got %b want 0", busy_o); end
    endtask

    task automatic test_spurious();
        drive_result(2'd2, 64'hDEAD, 1'b1, 1'b0);
        #1;
        checks++; if (id_error_o !== 1'b1 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL sp_pulse: got err=%b wb=%b want 1/0", id_error_o, wb_valid_o); end
        tick();
        checks++; if (id_error_o !== 1'b0) begin errors++; $display("FAIL sp_once: got %b want 0", id_error_o); end
    endtask

    task automatic test_reset_in_req();
        instr_valid_i = 1'b1; instr_i = 32'hABCD_0057;
        tick();
        instr_valid_i = 1'b0;
        #1;
        checks++; if (issue_valid_o !== 1'b1 || issue_id_o !== 2'd1) begin errors++; $display("FAIL rr_req: got %b/%0d want 1/1", issue_valid_o, issue_id_o); end
        rst_ni = 1'b0;
        issue_ready_i = 1'b1; issue_accept_i = 1'b1; issue_writeback_i = 1'b1;
        tick();
        rst_ni = 1'b1;
        issue_ready_i = 1'b0; issue_accept_i = 1'b0; issue_writeback_i = 1'b0;
        #1;
        checks++; if (issue_valid_o !== 1'b0 || busy_o !== 1'b0 || issue_id_o !== 2'd0) begin errors++; $display("FAIL rr_cleared: got valid=%b busy=%b id=%0d want 0/0/0", issue_valid_o, busy_o, issue_id_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_accept_writeback();
        test_backpressure();
        test_reject();
        test_id_exhaustion();
        test_spurious();
        test_reset_in_req();
        repeat (3) tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wb_missing: got %0d outstanding want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
